// File: rtl/rd_mode_select.sv
// Rate-distortion mode picker for intra macroblock decisions.
// Walks the enabled candidate modes in index order. For each one it asks the
// external reconstruct/cost engine for rate, SSE and spectral distortion. It
// scores the reply and keeps the cheapest candidate, with an optional early
// exit on a good-enough score. The winner is then rescored with the final
// lambda.
//
// Cost-engine handshake: eval_req is high for exactly one cycle (ISSUE) with
// eval_mode naming the candidate. eval_mode stays unchanged until the engine
// answers. The engine answers with a one-cycle eval_ack, and res_* are valid
// in that same cycle. An ack is accepted only in WAIT. An ack that arrives in
// any other state is dropped. abort overrides a simultaneous ack.
module rd_mode_select #(
  parameter int NUM_MODES = 4,
  parameter int MODE_W    = 4,
  parameter int PAYLOAD_W = 6432
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [NUM_MODES-1:0]   mode_mask,
  input  logic [31:0]            lambda,
  input  logic [31:0]            tlambda,
  input  logic [31:0]            lambda_final,
  input  logic [16*NUM_MODES-1:0] fixed_cost,
  input  logic [63:0]            early_thresh,
  output logic                   eval_req,
  output logic [MODE_W-1:0]      eval_mode,
  input  logic                   eval_ack,
  input  logic [31:0]            res_rate,
  input  logic [31:0]            res_sse,
  input  logic [31:0]            res_disto,
  input  logic [PAYLOAD_W-1:0]   res_payload,
  output logic [MODE_W-1:0]      best_mode,
  output logic [63:0]            best_score,
  output logic [PAYLOAD_W-1:0]   best_payload,
  output logic                   none_valid,
  output logic                   busy,
  output logic                   done,
  output logic [2:0]             dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SEEK  = 3'd1,
    S_ISSUE = 3'd2,
    S_WAIT  = 3'd3,
    S_SCORE = 3'd4,
    S_COMP  = 3'd5,
    S_FINAL = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  state_t state_q, state_d;

  // Decision configuration, captured at start so later input changes are harmless
  logic [NUM_MODES-1:0]    mask_q;
  logic [31:0]             lambda_q;
  logic [31:0]             tlambda_q;
  logic [31:0]             lfinal_q;
  logic [16*NUM_MODES-1:0] fixed_q;
  logic [63:0]             thresh_q;

  // Scan position and the reply for the mode being evaluated
  logic [MODE_W-1:0]    idx_q;
  logic [31:0]          r_q;
  logic [31:0]          d_q;
  logic [31:0]          sd_q;
  logic [PAYLOAD_W-1:0] pay_q;
  logic [63:0]          s_q;

  // Current winner
  logic                 have_win_q;
  logic [MODE_W-1:0]    win_mode_q;
  logic [31:0]          win_r_q;
  logic [31:0]          win_d_q;
  logic [31:0]          win_sd_q;
  logic [15:0]          win_h_q;
  logic [PAYLOAD_W-1:0] win_pay_q;
  logic [63:0]          win_score_q;

  // Combinational helpers
  logic        cur_bit;
  logic        bits_left;
  logic        last_idx;
  logic [15:0] h_sel;
  logic [63:0] score_new;
  logic [63:0] final_score;
  logic        replace;
  logic [63:0] win_score_next;
  logic        early_hit;

  // Mask lookups at the scan index: is the current mode enabled, and is any mode at or above it enabled
  always_comb begin
    cur_bit   = 1'b0;
    bits_left = 1'b0;
    h_sel     = 16'd0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (MODE_W'(i) == idx_q) begin
        cur_bit = mask_q[i];
        h_sel   = fixed_q[16*i +: 16];
      end
      if ((MODE_W'(i) >= idx_q) && mask_q[i]) bits_left = 1'b1;
    end
    last_idx = (idx_q == MODE_W'(NUM_MODES - 1));
  end

  // Candidate score with the per-mode lambda and the winner rescore with the final lambda (64-bit wrap)
  always_comb begin
    score_new   = (({32'd0, r_q} << 10) + {48'd0, h_sel}) * {32'd0, lambda_q}
                + ({32'd0, d_q} << 8) + {32'd0, sd_q} * {32'd0, tlambda_q};
    final_score = (({32'd0, win_r_q} << 10) + {48'd0, win_h_q}) * {32'd0, lfinal_q}
                + ({32'd0, win_d_q} << 8) + {32'd0, win_sd_q} * {32'd0, tlambda_q};
  end

  // Winner comparison: strict less-than so ties keep the earlier (lower) index
  always_comb begin
    replace        = !have_win_q || (s_q < win_score_q);
    win_score_next = replace ? s_q : win_score_q;
    early_hit      = (thresh_q != 64'd0) && (win_score_next < thresh_q);
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort from any busy state wins over everything else
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SEEK;
      S_SEEK: begin
        if (!bits_left)   state_d = have_win_q ? S_FINAL : S_DONE;
        else if (cur_bit) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (eval_ack) state_d = S_SCORE;
      S_SCORE: state_d = S_COMP;
      S_COMP:  state_d = (early_hit || last_idx) ? S_FINAL : S_SEEK;
      S_FINAL: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
  end

  // Capture the decision configuration when a decision starts
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q    <= '0;
      lambda_q  <= '0;
      tlambda_q <= '0;
      lfinal_q  <= '0;
      fixed_q   <= '0;
      thresh_q  <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      mask_q    <= mode_mask;
      lambda_q  <= lambda;
      tlambda_q <= tlambda;
      lfinal_q  <= lambda_final;
      fixed_q   <= fixed_cost;
      thresh_q  <= early_thresh;
    end
  end

  // Scan index: reset on start, stepped over disabled modes in SEEK and past evaluated ones in COMP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) idx_q <= '0;
    end else if (!abort) begin
      if ((state_q == S_SEEK) && bits_left && !cur_bit)
        idx_q <= idx_q + MODE_W'(1);
      else if ((state_q == S_COMP) && !early_hit && !last_idx)
        idx_q <= idx_q + MODE_W'(1);
    end
  end

  // Register the engine reply on ack in WAIT, then its score in SCORE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q   <= '0;
      d_q   <= '0;
      sd_q  <= '0;
      pay_q <= '0;
      s_q   <= '0;
    end else if (!abort) begin
      if ((state_q == S_WAIT) && eval_ack) begin
        r_q   <= res_rate;
        d_q   <= res_sse;
        sd_q  <= res_disto;
        pay_q <= res_payload;
      end
      if (state_q == S_SCORE) s_q <= score_new;
    end
  end

  // Winner bookkeeping: cleared on start, replaced in COMP on a strictly better score
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      have_win_q  <= 1'b0;
      win_mode_q  <= '0;
      win_r_q     <= '0;
      win_d_q     <= '0;
      win_sd_q    <= '0;
      win_h_q     <= '0;
      win_pay_q   <= '0;
      win_score_q <= '0;
    end else if (state_q == S_IDLE) begin
      if (start) have_win_q <= 1'b0;
    end else if (!abort && (state_q == S_COMP) && replace) begin
      have_win_q  <= 1'b1;
      win_mode_q  <= idx_q;
      win_r_q     <= r_q;
      win_d_q     <= d_q;
      win_sd_q    <= sd_q;
      win_h_q     <= h_sel;
      win_pay_q   <= pay_q;
      win_score_q <= s_q;
    end
  end

  // Published result: written on the edge into DONE so it is already valid while done pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_mode    <= '0;
      best_score   <= '0;
      best_payload <= '0;
      none_valid   <= 1'b0;
    end else if (!abort) begin
      if (state_q == S_FINAL) begin
        best_mode    <= win_mode_q;
        best_score   <= final_score;
        best_payload <= win_pay_q;
        none_valid   <= 1'b0;
      end else if ((state_q == S_SEEK) && !bits_left && !have_win_q) begin
        best_score <= '1;
        none_valid <= 1'b1;
      end
    end
  end

  assign eval_req  = (state_q == S_ISSUE);
  assign eval_mode = idx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_rd_mode_select.sv
// Testbench for rd_mode_select: directed scenarios plus randomized decisions.
// Results are compared against a list-walking reference model of the mode decision.
module tb_rd_mode_select;

  localparam int NUM_MODES = 4;
  localparam int MODE_W    = 4;
  localparam int PAYLOAD_W = 6432;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT connections ----------------
  logic                    start, abort;
  logic [NUM_MODES-1:0]    mode_mask;
  logic [31:0]             lambda, tlambda, lambda_final;
  logic [16*NUM_MODES-1:0] fixed_cost;
  logic [63:0]             early_thresh;
  logic                    eval_req;
  logic [MODE_W-1:0]       eval_mode;
  logic                    eval_ack;
  logic                    resp_ack, manual_ack;
  logic [31:0]             res_rate, res_sse, res_disto;
  logic [PAYLOAD_W-1:0]    res_payload;
  logic [MODE_W-1:0]       best_mode;
  logic [63:0]             best_score;
  logic [PAYLOAD_W-1:0]    best_payload;
  logic                    none_valid, busy, done;
  logic [2:0]              dbg_state;

  assign eval_ack = resp_ack | manual_ack;

  rd_mode_select #(.NUM_MODES(NUM_MODES), .MODE_W(MODE_W), .PAYLOAD_W(PAYLOAD_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode_mask(mode_mask),
    .lambda(lambda), .tlambda(tlambda), .lambda_final(lambda_final), .fixed_cost(fixed_cost),
    .early_thresh(early_thresh), .eval_req(eval_req), .eval_mode(eval_mode), .eval_ack(eval_ack),
    .res_rate(res_rate), .res_sse(res_sse), .res_disto(res_disto), .res_payload(res_payload),
    .best_mode(best_mode), .best_score(best_score), .best_payload(best_payload),
    .none_valid(none_valid), .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // ---------------- per-decision scenario ----------------
  logic [31:0]          ref_r  [NUM_MODES];
  logic [31:0]          ref_d  [NUM_MODES];
  logic [31:0]          ref_sd [NUM_MODES];
  logic [15:0]          ref_h  [NUM_MODES];
  logic [PAYLOAD_W-1:0] ref_pay[NUM_MODES];
  logic [NUM_MODES-1:0] cfg_mask;
  logic [31:0]          cfg_lambda, cfg_tl, cfg_lf;
  logic [63:0]          cfg_thresh;
  int                   stall_mode = 99;

  // ---------------- scoreboard ----------------
  logic [MODE_W-1:0]    exp_q[$];
  logic [MODE_W-1:0]    seen_q[$];
  logic [MODE_W-1:0]    exp_mode = '0;
  logic [63:0]          exp_score = '0;
  logic                 exp_none = 1'b0;
  logic [PAYLOAD_W-1:0] exp_pay = '0;
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_pay(input string tag, input logic [PAYLOAD_W-1:0] exp);
    checks++;
    assert (best_payload === exp) else begin
      errors++;
      $error("FAIL %s: observed[63:0]=%0h expected[63:0]=%0h", tag, best_payload[63:0], exp[63:0]);
    end
  endtask

  // ---------------- reference model ----------------
  // RD cost: (rate*1024 + header) * lam + sse*256 + disto * tlam, modulo 2^64
  function automatic logic [63:0] rd_cost(input logic [31:0] r, input logic [15:0] h,
                                          input logic [31:0] lam, input logic [31:0] d,
                                          input logic [31:0] sd, input logic [31:0] tl);
    logic [63:0] c;
    c = (64'(r) * 64'd1024 + 64'(h)) * 64'(lam) + 64'(d) * 64'd256 + 64'(sd) * 64'(tl);
    return c;
  endfunction

  // Walk enabled modes in order, keep the cheapest (first on ties), stop early when good enough
  task automatic model_run();
    bit          have;
    int          bm;
    logic [63:0] bs, s;
    exp_q.delete();
    have = 0; bm = 0; bs = '0;
    for (int i = 0; i < NUM_MODES; i++) begin
      if (cfg_mask[i]) begin
        exp_q.push_back(MODE_W'(i));
        s = rd_cost(ref_r[i], ref_h[i], cfg_lambda, ref_d[i], ref_sd[i], cfg_tl);
        if (!have || s < bs) begin have = 1; bs = s; bm = i; end
        if (cfg_thresh != 0 && bs < cfg_thresh) break;
      end
    end
    if (have) begin
      exp_mode  = MODE_W'(bm);
      exp_score = rd_cost(ref_r[bm], ref_h[bm], cfg_lf, ref_d[bm], ref_sd[bm], cfg_tl);
      exp_pay   = ref_pay[bm];
      exp_none  = 1'b0;
    end else begin
      exp_score = '1;
      exp_none  = 1'b1;
    end
  endtask

  // ---------------- cost engine responder ----------------
  initial begin
    int m, n;
    resp_ack = 0; res_rate = 0; res_sse = 0; res_disto = 0; res_payload = '0;
    forever begin
      @(posedge clk); #1;
      if (eval_req) begin
        m = int'(eval_mode);
        seen_q.push_back(eval_mode);
        if (m != stall_mode && m < NUM_MODES) begin
          @(posedge clk); #1;
          n = $urandom_range(0, 3);
          for (int k = 0; k < n; k++) begin @(posedge clk); #1; end
          res_rate = ref_r[m]; res_sse = ref_d[m]; res_disto = ref_sd[m]; res_payload = ref_pay[m];
          resp_ack = 1;
          @(posedge clk); #1;
          resp_ack = 0;
          res_rate = $urandom(); res_sse = $urandom(); res_disto = $urandom();
          res_payload = {PAYLOAD_W{1'b1}};
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic fill_payloads();
    for (int i = 0; i < NUM_MODES; i++)
      for (int w = 0; w < PAYLOAD_W / 32; w++) ref_pay[i][32*w +: 32] = $urandom();
  endtask

  task automatic set_base(input logic [31:0] r0, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] r3);
    cfg_mask = 4'hF; cfg_lambda = 1; cfg_tl = 0; cfg_lf = 2; cfg_thresh = 0;
    ref_r[0] = r0; ref_r[1] = r1; ref_r[2] = r2; ref_r[3] = r3;
    for (int i = 0; i < NUM_MODES; i++) begin ref_h[i] = 0; ref_d[i] = 0; ref_sd[i] = 0; end
    fill_payloads();
  endtask

  task automatic drive_start();
    mode_mask = cfg_mask; lambda = cfg_lambda; tlambda = cfg_tl; lambda_final = cfg_lf;
    early_thresh = cfg_thresh;
    for (int i = 0; i < NUM_MODES; i++) fixed_cost[16*i +: 16] = ref_h[i];
    seen_q.delete();
    start = 1;
    @(posedge clk); #1;
    start = 0;
    // Scramble inputs: the decision must use the values captured at start
    mode_mask = NUM_MODES'($urandom()); lambda = $urandom(); tlambda = $urandom();
    lambda_final = $urandom(); early_thresh = {$urandom(), $urandom()};
    fixed_cost = {$urandom(), $urandom()};
  endtask

  task automatic run_decision(input string tag, output int lat);
    int cyc;
    int d0;
    model_run();
    d0 = done_cnt;
    drive_start();
    cyc = 1;
    while (!done && cyc < 400) begin @(posedge clk); #1; cyc++; end
    lat = cyc;
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_nreq"}, 64'(seen_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < seen_q.size(); i++)
      check($sformatf("%s_mode%0d", tag, i), 64'(seen_q[i]), 64'(exp_q[i]));
    check({tag, "_best_mode"}, 64'(best_mode), 64'(exp_mode));
    check({tag, "_best_score"}, best_score, exp_score);
    check({tag, "_none"}, 64'(none_valid), 64'(exp_none));
    check_pay({tag, "_payload"}, exp_pay);
    @(posedge clk); #1;
    check({tag, "_pulse"}, 64'(done_cnt - d0), 64'd1);
    check({tag, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic wait_req_for(input int mode);
    int cyc;
    cyc = 0;
    while (!(seen_q.size() > 0 && int'(seen_q[$]) == mode) && cyc < 200) begin
      @(posedge clk); #1; cyc++;
    end
    check($sformatf("req_for_mode%0d", mode), 64'(cyc < 200), 64'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_eval_req"}, 64'(eval_req), 64'd0);
    check({tag, "_eval_mode"}, 64'(eval_mode), 64'd0);
    check({tag, "_best_mode"}, 64'(best_mode), 64'd0);
    check({tag, "_best_score"}, best_score, 64'd0);
    check_pay({tag, "_payload"}, '0);
    check({tag, "_none"}, 64'(none_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, d0;
    logic [MODE_W-1:0] hold_mode;
    logic [63:0]       hold_score;
    start = 0; abort = 0; manual_ack = 0; mode_mask = 0; lambda = 0; tlambda = 0;
    lambda_final = 0; fixed_cost = 0; early_thresh = 0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1;
    @(posedge clk); #1;

    // T1: plain scan of all four modes, mode 1 cheapest
    set_base(3, 1, 2, 5);
    run_decision("T1", lat);
    check("T1_score_const", best_score, 64'd2048);

    // T2: all equal, lowest index wins
    set_base(2, 2, 2, 2);
    run_decision("T2", lat);
    check("T2_score_const", best_score, 64'd4096);

    // T3: sparse mask, only modes 1 and 3 requested
    set_base(9, 4, 9, 3);
    cfg_mask = 4'b1010;
    run_decision("T3", lat);
    check("T3_score_const", best_score, 64'd6144);

    // T4: early exit after the first mode
    set_base(1, 0, 0, 0);
    cfg_thresh = 1500;
    run_decision("T4", lat);
    check("T4_score_const", best_score, 64'd2048);

    // T5: abort while waiting on mode 2, simultaneous and late acks ignored
    hold_mode = best_mode; hold_score = best_score;
    set_base(7, 6, 0, 0);
    stall_mode = 2;
    d0 = done_cnt;
    drive_start();
    wait_req_for(2);
    @(posedge clk); #1;
    check("T5_busy_in_wait", 64'(busy), 64'd1);
    abort = 1; manual_ack = 1;
    res_rate = 0; res_sse = 0; res_disto = 0; res_payload = '0;
    @(posedge clk); #1;
    abort = 0;
    check("T5_idle_after_abort", 64'(busy), 64'd0);
    @(posedge clk); #1;
    manual_ack = 0;
    @(posedge clk); #1;
    check("T5_still_idle", 64'(busy), 64'd0);
    check("T5_no_done", 64'(done_cnt - d0), 64'd0);
    check("T5_best_mode", 64'(best_mode), 64'(hold_mode));
    check("T5_best_score", best_score, hold_score);
    check_pay("T5_payload", exp_pay);
    stall_mode = 99;

    // New decision after abort works normally
    set_base(5, 5, 4, 5);
    run_decision("T5b", lat);

    // T6: empty mask
    set_base(1, 1, 1, 1);
    cfg_mask = 4'b0000;
    run_decision("T6", lat);
    check("T6_latency_ok", 64'(lat <= 4), 64'd1);

    // Randomized decisions
    for (int it = 0; it < 40; it++) begin
      cfg_mask   = NUM_MODES'($urandom_range(0, 15));
      cfg_lambda = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 8) : $urandom();
      cfg_tl     = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 8) : $urandom();
      cfg_lf     = $urandom();
      cfg_thresh = ($urandom_range(0, 2) == 0) ? 64'd0 : 64'($urandom_range(0, 60000));
      for (int i = 0; i < NUM_MODES; i++) begin
        ref_r[i]  = ($urandom_range(0, 3) != 0) ? $urandom_range(0, 7) : $urandom();
        ref_d[i]  = ($urandom_range(0, 1) != 0) ? $urandom_range(0, 4) : $urandom();
        ref_sd[i] = $urandom_range(0, 15);
        ref_h[i]  = 16'($urandom_range(0, 3));
      end
      fill_payloads();
      run_decision($sformatf("R%0d", it), lat);
    end

    // Reset in the middle of WAIT clears every output at once
    set_base(4, 3, 2, 1);
    stall_mode = 1;
    drive_start();
    wait_req_for(1);
    @(posedge clk); #1;
    rst_n = 0;
    #1;
    check_all_zero("midreset");
    stall_mode = 99;
    @(posedge clk); #1;
    rst_n = 1;
    @(posedge clk); #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
